aes_encrypt_iter: RTL and testbench

AES_ENCRYPT_ITER -- requirements
Module: aes_encrypt_iter

---
 rtl/aes_pkg.sv | 76 +++++++
 rtl/aes_sbox.sv | 11 +
 rtl/aes_encrypt_iter.sv | 113 +++++++++++
 tb/tb_aes_encrypt_iter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round count, RCON, forward S-box and the
// byte-level round transforms, also used by the key expansion logic.
package aes_pkg;

  localparam logic [3:0] AES_NR = 4'd10;

  localparam logic [1:10][7:0] AES_RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [0:255][7:0] AES_SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } aes_fsm_e;

  function automatic logic [7:0] aes_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] aes_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      o[127-8*i -: 8] = AES_SBOX[s[127-8*i -: 8]];
    end
    return o;
  endfunction

  // Byte k of the block sits at row k%4, column k/4.
  function automatic logic [127:0] aes_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] aes_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a [4];
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        a[r] = s[127-8*(4*c+r) -: 8];
      end
      for (int unsigned r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = aes_xtime(a[r]) ^ aes_xtime(a[(r+1)%4]) ^ a[(r+1)%4]
                              ^ a[(r+2)%4] ^ a[(r+3)%4];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, one byte, purely combinational.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] i_data,
  output logic [7:0] o_data
);

  assign o_data = AES_SBOX[i_data];

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryptor: one round per clock on a single state
// register, ten rounds per block, externally supplied round keys.
module aes_encrypt_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] plaintext,
  input  logic [127:0] round_key0,
  input  logic [127:0] round_key1,
  input  logic [127:0] round_key2,
  input  logic [127:0] round_key3,
  input  logic [127:0] round_key4,
  input  logic [127:0] round_key5,
  input  logic [127:0] round_key6,
  input  logic [127:0] round_key7,
  input  logic [127:0] round_key8,
  input  logic [127:0] round_key9,
  input  logic [127:0] round_key10,
  output logic         busy,
  output logic         done,
  output logic [127:0] ciphertext
);

  aes_fsm_e     r_fsm;
  logic [3:0]   r_cnt;
  logic [127:0] r_state;
  logic         r_busy;
  logic         r_done;
  logic [127:0] r_ct;

  logic [127:0] w_sb;
  logic [127:0] w_sr;
  logic [127:0] w_mc;
  logic [127:0] w_rk;
  logic [127:0] w_next;

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_sbox u_sbox (
      .i_data (r_state[127-8*i -: 8]),
      .o_data (w_sb[127-8*i -: 8])
    );
  end

  assign w_sr = aes_shift_rows(w_sb);
  assign w_mc = aes_mix_columns(w_sr);

  always_comb begin
    w_rk = '0;
    case (r_cnt)
      4'd1:    w_rk = round_key1;
      4'd2:    w_rk = round_key2;
      4'd3:    w_rk = round_key3;
      4'd4:    w_rk = round_key4;
      4'd5:    w_rk = round_key5;
      4'd6:    w_rk = round_key6;
      4'd7:    w_rk = round_key7;
      4'd8:    w_rk = round_key8;
      4'd9:    w_rk = round_key9;
      4'd10:   w_rk = round_key10;
      default: w_rk = '0;
    endcase
  end

  // Final round skips MixColumns.
  assign w_next = ((r_cnt == AES_NR) ? w_sr : w_mc) ^ w_rk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm   <= ST_IDLE;
      r_cnt   <= '0;
      r_state <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ct    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_fsm)
        ST_IDLE: begin
          if (start) begin
            r_state <= plaintext ^ round_key0;
            r_cnt   <= 4'd1;
            r_busy  <= 1'b1;
            r_fsm   <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_state <= w_next;
          if (r_cnt == AES_NR) begin
            r_ct   <= w_next;
            r_done <= 1'b1;
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_fsm  <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: begin
          r_fsm  <= ST_IDLE;
          r_busy <= 1'b0;
          r_cnt  <= '0;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign ciphertext = r_ct;

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Bench for aes_encrypt_iter: known-answer vectors plus random blocks checked
// against an independent AES model built from GF(2^8) arithmetic.
module tb_aes_encrypt_iter;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] plaintext;
  logic [127:0] drv_rk [11];
  logic         busy;
  logic         done;
  logic [127:0] ciphertext;

  int checks;
  int failures;

  logic [7:0]   m_sbox [256];
  logic [127:0] rk [11];

  aes_encrypt_iter dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .plaintext   (plaintext),
    .round_key0  (drv_rk[0]),
    .round_key1  (drv_rk[1]),
    .round_key2  (drv_rk[2]),
    .round_key3  (drv_rk[3]),
    .round_key4  (drv_rk[4]),
    .round_key5  (drv_rk[5]),
    .round_key6  (drv_rk[6]),
    .round_key7  (drv_rk[7]),
    .round_key8  (drv_rk[8]),
    .round_key9  (drv_rk[9]),
    .round_key10 (drv_rk[10]),
    .busy        (busy),
    .done        (done),
    .ciphertext  (ciphertext)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ ({8'h00, a} << i);
    for (int k = 15; k >= 8; k--) if (p[k]) p = p ^ (16'h011b << (k - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] x;
    x = b;
    for (int i = 0; i < n; i++) x = {x[6:0], x[7]};
    return x;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      m_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {m_sbox[t[31:24]], m_sbox[t[23:16]], m_sbox[t[15:8]], m_sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // State after the given number of rounds, using the current rk[] schedule.
  function automatic logic [127:0] model_encrypt(input logic [127:0] pt, input int rounds);
    logic [7:0]   st [4][4];
    logic [7:0]   t  [4][4];
    logic [127:0] res;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        st[r][c] = pt[127-8*(4*c+r) -: 8] ^ rk[0][127-8*(4*c+r) -: 8];
    for (int rnd = 1; rnd <= rounds; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = m_sbox[st[r][(c+r)%4]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) begin
          if (rnd < 10)
            st[r][c] = gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1)%4][c])
                     ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
          else
            st[r][c] = t[r][c];
          st[r][c] = st[r][c] ^ rk[rnd][127-8*(4*c+r) -: 8];
        end
    end
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127-8*(4*c+r) -: 8] = st[r][c];
    return res;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [127:0] pt);
    plaintext = pt;
    for (int r = 0; r < 11; r++) drv_rk[r] = rk[r];
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Returns edges counted since the accepting edge, or 0 on timeout.
  task automatic wait_done(input int already, output int lat);
    lat = 0;
    for (int c = already + 1; c <= 40; c++) begin
      tick();
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (ciphertext !== 128'h0) begin failures++; $display("FAIL reset_ct: got %h expected 0", ciphertext); end
    checks++; if (dut.r_state !== 128'h0) begin failures++; $display("FAIL reset_state: got %h expected 0", dut.r_state); end
    rst = 1'b0;
  endtask

  task automatic test_fips_c1();
    int lat;
    expand_key(128'h000102030405060708090a0b0c0d0e0f);
    launch(128'h00112233445566778899aabbccddeeff);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL c1_busy_after_start: got %b expected 1", busy); end
    wait_done(0, lat);
    checks++; if (lat != 10) begin failures++; $display("FAIL c1_latency: got %0d expected 10", lat); end
    checks++; if (ciphertext !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin
      failures++; $display("FAIL c1_ct: got %h expected 69c4e0d86a7b0430d8cdb78070b4c55a", ciphertext); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL c1_busy_at_done: got %b expected 0", busy); end
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL c1_done_width: got %b expected 0", done); end
  endtask

  task automatic test_fips_b();
    int lat;
    expand_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    launch(128'h3243f6a8885a308d313198a2e0370734);
    tick();
    checks++; if (dut.r_state !== 128'ha49c7ff2689f352b6b5bea43026a5049) begin
      failures++; $display("FAIL b_round1: got %h expected a49c7ff2689f352b6b5bea43026a5049", dut.r_state); end
    wait_done(1, lat);
    checks++; if (lat != 10) begin failures++; $display("FAIL b_latency: got %0d expected 10", lat); end
    checks++; if (ciphertext !== 128'h3925841d02dc09fbdc118597196a0b32) begin
      failures++; $display("FAIL b_ct: got %h expected 3925841d02dc09fbdc118597196a0b32", ciphertext); end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat;
    int gap;
    expand_key(128'h000102030405060708090a0b0c0d0e0f);
    launch(128'h00112233445566778899aabbccddeeff);
    wait_done(0, lat);
    checks++; if (lat != 10) begin failures++; $display("FAIL b2b_first_latency: got %0d expected 10", lat); end
    checks++; if (ciphertext !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin
      failures++; $display("FAIL b2b_first_ct: got %h expected 69c4e0d86a7b0430d8cdb78070b4c55a", ciphertext); end
    expand_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    launch(128'h3243f6a8885a308d313198a2e0370734);
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin
      failures++; $display("FAIL b2b_accept: got busy=%b done=%b expected busy=1 done=0", busy, done); end
    gap = 1;
    wait_done(0, lat);
    gap = gap + lat - 1;
    checks++; if (lat != 10) begin failures++; $display("FAIL b2b_second_latency: got %0d expected 10", lat); end
    checks++; if (gap != 10) begin failures++; $display("FAIL b2b_idle_between_dones: got %0d expected 10", gap); end
    checks++; if (ciphertext !== 128'h3925841d02dc09fbdc118597196a0b32) begin
      failures++; $display("FAIL b2b_second_ct: got %h expected 3925841d02dc09fbdc118597196a0b32", ciphertext); end
    tick();
  endtask

  task automatic test_busy_ignore();
    logic [127:0] pt;
    logic [127:0] exp_ct;
    int ndone;
    int at;
    expand_key({$urandom(), $urandom(), $urandom(), $urandom()});
    pt = {$urandom(), $urandom(), $urandom(), $urandom()};
    exp_ct = model_encrypt(pt, 10);
    launch(pt);
    ndone = 0;
    at = 0;
    for (int c = 1; c <= 25; c++) begin
      start = (c == 3 || c == 7);
      if (start) plaintext = ~pt;
      tick();
      if (done) begin
        ndone++;
        at = c;
      end
    end
    start = 1'b0;
    checks++; if (ndone != 1 || at != 10) begin
      failures++; $display("FAIL ignore_done: got count=%0d at=%0d expected count=1 at=10", ndone, at); end
    checks++; if (ciphertext !== exp_ct) begin
      failures++; $display("FAIL ignore_ct: got %h expected %h", ciphertext, exp_ct); end
  endtask

  task automatic test_reset_midrun();
    logic [127:0] pt;
    logic [127:0] exp_ct;
    int lat;
    int seen;
    expand_key({$urandom(), $urandom(), $urandom(), $urandom()});
    pt = {$urandom(), $urandom(), $urandom(), $urandom()};
    launch(pt);
    for (int c = 0; c < 4; c++) tick();
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || ciphertext !== 128'h0) begin
      failures++; $display("FAIL midrun_async_clear: got busy=%b done=%b ct=%h expected 0/0/0", busy, done, ciphertext); end
    tick();
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done || busy) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL midrun_no_done: got %0d active cycles expected 0", seen); end
    pt = {$urandom(), $urandom(), $urandom(), $urandom()};
    exp_ct = model_encrypt(pt, 10);
    launch(pt);
    wait_done(0, lat);
    checks++; if (lat != 10) begin failures++; $display("FAIL midrun_restart_latency: got %0d expected 10", lat); end
    checks++; if (ciphertext !== exp_ct) begin failures++; $display("FAIL midrun_restart_ct: got %h expected %h", ciphertext, exp_ct); end
    tick();
  endtask

  task automatic test_zero();
    int lat;
    expand_key(128'h0);
    launch(128'h0);
    wait_done(0, lat);
    checks++; if (lat != 10) begin failures++; $display("FAIL zero_latency: got %0d expected 10", lat); end
    checks++; if (ciphertext !== 128'h66e94bd4ef8a2c3b884cfa59ca342b2e) begin
      failures++; $display("FAIL zero_ct: got %h expected 66e94bd4ef8a2c3b884cfa59ca342b2e", ciphertext); end
    for (int c = 0; c < 20; c++) begin
      plaintext = {$urandom(), $urandom(), $urandom(), $urandom()};
      tick();
      checks++; if (ciphertext !== 128'h66e94bd4ef8a2c3b884cfa59ca342b2e || done !== 1'b0) begin
        failures++; $display("FAIL zero_hold: cycle %0d got ct=%h done=%b expected 66e94bd4ef8a2c3b884cfa59ca342b2e done=0", c, ciphertext, done); end
    end
  endtask

  task automatic test_random();
    logic [127:0] pt;
    logic [127:0] exp_ct;
    int lat;
    for (int n = 0; n < 16; n++) begin
      expand_key({$urandom(), $urandom(), $urandom(), $urandom()});
      pt = {$urandom(), $urandom(), $urandom(), $urandom()};
      exp_ct = model_encrypt(pt, 10);
      launch(pt);
      lat = 0;
      for (int c = 1; c <= 30; c++) begin
        start = (c < 10) && ($urandom_range(0, 3) == 0);
        plaintext = {$urandom(), $urandom(), $urandom(), $urandom()};
        tick();
        if (done) begin
          lat = c;
          break;
        end
      end
      start = 1'b0;
      checks++; if (lat != 10) begin failures++; $display("FAIL rand%0d_latency: got %0d expected 10", n, lat); end
      checks++; if (ciphertext !== exp_ct) begin failures++; $display("FAIL rand%0d_ct: got %h expected %h", n, ciphertext, exp_ct); end
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    start     = 1'b0;
    plaintext = '0;
    for (int r = 0; r < 11; r++) drv_rk[r] = '0;
    build_sbox();
    test_reset();
    test_fips_c1();
    test_fips_b();
    test_back_to_back();
    test_busy_ignore();
    test_reset_midrun();
    test_zero();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
